// File: rtl/eq_i2s_sample_feeder_if.sv
// EQ-side sample handshake for the I2S feeder.
// The feeder is the master; the EQ is the slave.
interface eq_i2s_sample_feeder_if #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              send_next_sample;
  logic              clear_overflow;
  logic [DATA_W-1:0] sample_out;
  logic              sample_is_right;
  logic              sample_valid;
  logic [LW-1:0]     fifo_level;
  logic              overflow;

  modport master (
    input  send_next_sample,
    input  clear_overflow,
    output sample_out,
    output sample_is_right,
    output sample_valid,
    output fifo_level,
    output overflow
  );

  modport slave (
    output send_next_sample,
    output clear_overflow,
    input  sample_out,
    input  sample_is_right,
    input  sample_valid,
    input  fifo_level,
    input  overflow
  );
endinterface

// File: rtl/eq_i2s_sample_feeder.sv
// I2S receiver feeding the parametric EQ.
// Oversampled deserializer plus a small FWFT sample FIFO.
module eq_i2s_sample_feeder #(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic alg_clk,
  input  logic resetn,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdata,
  eq_i2s_sample_feeder_if.master eq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE, ARM, SHIFT, HOLD
  } state_t;

  typedef struct packed {
    logic              right;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [SYNC_STAGES-1:0] bclk_sy;
  logic [SYNC_STAGES-1:0] lr_sy;
  logic [SYNC_STAGES-1:0] sd_sy;
  logic bclk_s, lr_s, sd_s;
  logic bclk_prev, lrclk_prev;
  logic bit_tick, frame_edge;

  assign bclk_s = bclk_sy[SYNC_STAGES-1];
  assign lr_s   = lr_sy[SYNC_STAGES-1];
  assign sd_s   = sd_sy[SYNC_STAGES-1];

  assign bit_tick   = bclk_s & ~bclk_prev;
  assign frame_edge = bit_tick & (lr_s ^ lrclk_prev);

  always_ff @(posedge alg_clk) begin
    if (resetn) begin
      bclk_sy    <= '0;
      lr_sy      <= '0;
      sd_sy      <= '0;
      bclk_prev  <= 1'b0;
      lrclk_prev <= 1'b0;
    end else begin
      bclk_sy   <= SYNC_STAGES'({bclk_sy, i2s_bclk});
      lr_sy     <= SYNC_STAGES'({lr_sy, i2s_lrclk});
      sd_sy     <= SYNC_STAGES'({sd_sy, i2s_sdata});
      bclk_prev <= bclk_s;
      if (bit_tick)
        lrclk_prev <= lr_s;
    end
  end

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              chan;
  logic              push_q;
  logic [DATA_W-1:0] push_word;
  logic              push_chan;
  logic [DATA_W-1:0] shifted;
  logic [CW-1:0]     cnt_nxt;

  assign shifted = {shreg[DATA_W-2:0], sd_s};
  assign cnt_nxt = bit_cnt + 1'b1;

  // The bit on a frame-edge tick is the LSB of the word being closed.
  always_ff @(posedge alg_clk) begin
    if (resetn) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      chan      <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
      push_chan <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (bit_tick) begin
        unique case (state)
          IDLE: begin
            if (frame_edge) begin
              chan  <= lr_s;
              state <= ARM;
            end
          end
          ARM: begin
            if (frame_edge) begin
              chan <= lr_s;
            end else begin
              shreg   <= {{(DATA_W-1){1'b0}}, sd_s};
              bit_cnt <= CW'(1);
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            shreg   <= shifted;
            bit_cnt <= cnt_nxt;
            if (cnt_nxt == CW'(DATA_W)) begin
              push_q    <= 1'b1;
              push_word <= shifted;
              push_chan <= chan;
              if (frame_edge) begin
                chan  <= lr_s;
                state <= ARM;
              end else begin
                state <= HOLD;
              end
            end else if (frame_edge) begin
              push_q    <= 1'b1;
              push_word <= shifted << (DATA_W - int'(cnt_nxt));
              push_chan <= chan;
              chan      <= lr_s;
              state     <= ARM;
            end
          end
          HOLD: begin
            if (frame_edge) begin
              chan  <= lr_s;
              state <= ARM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic          empty, full;
  logic          do_pop, do_push, drop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign do_pop  = eq.send_next_sample & ~empty;
  assign do_push = push_q & (~full | do_pop);
  assign drop    = push_q & full & ~do_pop;

  always_ff @(posedge alg_clk) begin
    if (do_push)
      mem[wr_ptr] <= '{right: push_chan, data: push_word};
  end

  always_ff @(posedge alg_clk) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (eq.clear_overflow)
        ovf <= 1'b0;
      else if (drop)
        ovf <= 1'b1;
    end
  end

  assign eq.sample_out      = empty ? '0 : mem[rd_ptr].data;
  assign eq.sample_is_right = empty ? 1'b0 : mem[rd_ptr].right;
  assign eq.sample_valid    = ~empty;
  assign eq.fifo_level      = level;
  assign eq.overflow        = ovf;

endmodule

// File: tb/tb_eq_i2s_sample_feeder.sv
// Scoreboard bench for the I2S sample feeder.
// Drives an I2S stream at alg_clk/8 and checks FIFO pops.
module tb_eq_i2s_sample_feeder;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic bclk   = 1'b0;
  logic lrclk  = 1'b0;
  logic sdata  = 1'b0;

  always #5 clk = ~clk;

  eq_i2s_sample_feeder_if #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) eq_if ();

  eq_i2s_sample_feeder #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)
  ) dut (
    .alg_clk  (clk),
    .resetn   (resetn),
    .i2s_bclk (bclk),
    .i2s_lrclk(lrclk),
    .i2s_sdata(sdata),
    .eq       (eq_if)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [DW:0] sb [$];
  bit  cur_ch     = 1'b0;
  int  lsb_cyc    = 0;
  int  rise_cyc   = 0;
  bit  prev_valid = 1'b0;
  int  max_lvl    = 0;
  int  valid_hi   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always begin
    logic [DW:0] e;
    @(negedge clk);
    #1;
    if (!resetn) begin
      if (eq_if.sample_valid && !prev_valid)
        rise_cyc = cyc;
      prev_valid = eq_if.sample_valid;
      if (int'(eq_if.fifo_level) > max_lvl)
        max_lvl = int'(eq_if.fifo_level);
      if (eq_if.sample_valid)
        valid_hi++;
      if (eq_if.send_next_sample && eq_if.sample_valid) begin
        if (sb.size() == 0) begin
          check("sb_underrun", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pop_data", 32'(eq_if.sample_out), 32'(e[DW-1:0]));
          check("pop_chan", 32'(eq_if.sample_is_right), 32'(e[DW]));
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send_bit(input logic lr, input logic sd,
                          input bit mark, input bit pop_at_push);
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (mark)
      lsb_cyc = cyc;
    if (pop_at_push) begin
      repeat (3) @(negedge clk);
      eq_if.send_next_sample = 1'b1;
      @(negedge clk);
      eq_if.send_next_sample = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_slot(input logic [DW-1:0] w, input int n,
                           input int s, input bit exp,
                           input bit pop_at_push);
    logic [DW-1:0] ev;
    ev = w << (DW - n);
    if (exp)
      sb.push_back({cur_ch, ev});
    for (int k = 0; k < s; k++)
      send_bit((k == s - 1) ? ~cur_ch : cur_ch,
               (k < n) ? w[n-1-k] : 1'b0,
               k == n - 1, pop_at_push && (k == n - 1));
    cur_ch = ~cur_ch;
  endtask

  task automatic preamble(input bit c);
    send_bit(~c, 1'b0, 1'b0, 1'b0);
    send_bit(c, 1'b0, 1'b0, 1'b0);
    cur_ch = c;
  endtask

  task automatic drain();
    int i;
    i = 0;
    eq_if.send_next_sample = 1'b1;
    while (eq_if.sample_valid && i < 40) begin
      @(negedge clk);
      i++;
    end
    eq_if.send_next_sample = 1'b0;
    check("drain_valid", 32'(eq_if.sample_valid), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"},   32'(eq_if.sample_out), 32'd0);
    check({tag, "_right"}, 32'(eq_if.sample_is_right), 32'd0);
    check({tag, "_valid"}, 32'(eq_if.sample_valid), 32'd0);
    check({tag, "_level"}, 32'(eq_if.fifo_level), 32'd0);
    check({tag, "_ovf"},   32'(eq_if.overflow), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    eq_if.send_next_sample = 1'b0;
    eq_if.clear_overflow   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    preamble(1'b0);
    send_slot(24'h123456, 24, 32, 1'b1, 1'b0);
    send_slot(24'hFEDCBA, 24, 32, 1'b1, 1'b0);
    send_slot(24'h000001, 24, 32, 1'b1, 1'b0);
    send_slot(24'h800000, 24, 32, 1'b1, 1'b0);
    check("fill_level", 32'(eq_if.fifo_level), 32'd4);
    check("fill_ovf", 32'(eq_if.overflow), 32'd0);
    drain();

    send_slot(24'h7FFFFF, 24, 32, 1'b1, 1'b0);
    check("latency", 32'(rise_cyc - lsb_cyc), 32'(SS + 2));
    check("lat_data", 32'(eq_if.sample_out), 32'h7FFFFF);
    check("lat_right", 32'(eq_if.sample_is_right), 32'd0);
    drain();

    send_slot(24'h111111, 24, 32, 1'b1, 1'b0);
    send_slot(24'h222222, 24, 32, 1'b1, 1'b0);
    send_slot(24'h333333, 24, 32, 1'b1, 1'b0);
    send_slot(24'h444444, 24, 32, 1'b1, 1'b0);
    send_slot(24'h555555, 24, 32, 1'b0, 1'b0);
    check("drop_level", 32'(eq_if.fifo_level), 32'd4);
    check("drop_ovf", 32'(eq_if.overflow), 32'd1);
    eq_if.clear_overflow = 1'b1;
    @(negedge clk);
    eq_if.clear_overflow = 1'b0;
    check("clr_ovf", 32'(eq_if.overflow), 32'd0);
    drain();

    send_slot(24'hA00001, 24, 32, 1'b1, 1'b0);
    send_slot(24'hA00002, 24, 32, 1'b1, 1'b0);
    send_slot(24'hA00003, 24, 32, 1'b1, 1'b0);
    send_slot(24'hA00004, 24, 32, 1'b1, 1'b0);
    send_slot(24'hA00005, 24, 32, 1'b1, 1'b1);
    check("pp_level", 32'(eq_if.fifo_level), 32'd4);
    check("pp_ovf", 32'(eq_if.overflow), 32'd0);
    drain();

    send_slot(24'h00ABCD, 16, 16, 1'b1, 1'b0);
    send_slot(24'h5A5A5A, 24, 32, 1'b1, 1'b0);
    drain();

    send_slot(24'h135790, 24, 32, 1'b1, 1'b0);
    drain();
    send_slot(24'h246801, 24, 32, 1'b1, 1'b0);
    send_slot(24'hC0FFEE, 24, 32, 1'b1, 1'b0);
    check("pre_rst_level", 32'(eq_if.fifo_level), 32'd2);
    for (int k = 0; k < 10; k++)
      send_bit(1'b0, k[0], 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("midrst");
    sb.delete();
    resetn = 1'b0;
    for (int k = 10; k < 32; k++)
      send_bit(k == 31, 1'b1, 1'b0, 1'b0);
    cur_ch = 1'b1;
    send_slot(24'h0F0F0F, 24, 32, 1'b1, 1'b0);
    send_slot(24'h00FF00, 24, 32, 1'b1, 1'b0);
    drain();

    max_lvl  = 0;
    valid_hi = 0;
    eq_if.send_next_sample = 1'b1;
    send_slot(24'h987654, 24, 32, 1'b1, 1'b0);
    send_slot(24'h000000, 24, 32, 1'b1, 1'b0);
    send_slot(24'hFFFFFF, 24, 32, 1'b1, 1'b0);
    send_slot(24'h456789, 24, 32, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    eq_if.send_next_sample = 1'b0;
    check("stream_max_lvl", 32'(max_lvl), 32'd1);
    check("stream_valid_hi", 32'(valid_hi), 32'd4);
    check("stream_sb_left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
